// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Report channel between the deadlock supervisor and the testbench log sink.
// The supervisor drives one entry at a time. The sink accepts it with rpt_ready.
interface aesl_deadlock_report_ctrl_if #(
  parameter int IDX_W  = 1,
  parameter int INFO_W = 1
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [IDX_W-1:0]  rpt_idx;
  logic [INFO_W-1:0] rpt_info;
  logic              rpt_last;

  modport master (
    output rpt_valid,
    output rpt_idx,
    output rpt_info,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_idx,
    input  rpt_info,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/aesl_deadlock_report_ctrl.sv
// Deadlock supervisor for the dataflow-region monitors.
// The supervisor arms on ap_start and requires a block flag to persist for
// CONFIRM_CYCLES cycles in a row. It then snapshots the blocked monitors and
// their info, and reports each of them serially on the rpt channel.
// After the final entry is accepted, it holds a sticky sim_abort until reset.
module aesl_deadlock_report_ctrl #(
  parameter int NUM_MON        = 2,
  parameter int INFO_W         = 1,
  parameter int IDX_W          = 1,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic                      ap_done,
  input  logic [NUM_MON-1:0]        mon_block,
  input  logic [NUM_MON*INFO_W-1:0] mon_axis_info,
  aesl_deadlock_report_ctrl_if.master rpt,
  output logic                      deadlock,
  output logic                      sim_abort
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, CONFIRM, REPORT, HALT} state_t;

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [NUM_MON-1:0]        pending, pending_next;
  logic [NUM_MON*INFO_W-1:0] info_regs, info_next;

  logic                      valid_q, last_q, deadlock_q, abort_q;
  logic [IDX_W-1:0]          idx_q;
  logic [INFO_W-1:0]         info_q;

  logic                      any_block, snapshot, accept;
  logic [IDX_W-1:0]          sel_idx;
  logic [INFO_W-1:0]         sel_info;
  logic                      sel_last;

  assign any_block = |mon_block;
  assign accept    = valid_q & rpt.rpt_ready;

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_idx   = idx_q;
  assign rpt.rpt_info  = info_q;
  assign rpt.rpt_last  = last_q;
  assign deadlock      = deadlock_q;
  assign sim_abort     = abort_q;

  // Next-state logic: persistence counting, snapshot on the confirming edge, report draining
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    info_next    = info_regs;
    snapshot     = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) state_next = ARMED;
      end
      ARMED: begin
        if (ap_done) begin
          state_next = IDLE;
        end else if (any_block) begin
          if (CONFIRM_CYCLES == 1) begin
            snapshot = 1'b1;
          end else begin
            state_next = CONFIRM;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      CONFIRM: begin
        if (ap_done) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!any_block) begin
          state_next = ARMED;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(CONFIRM_CYCLES - 1)) begin
          snapshot = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      REPORT: begin
        if (accept) begin
          pending_next = pending & ~(NUM_MON'(1) << idx_q);
          if (last_q) state_next = HALT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
    if (snapshot) begin
      state_next   = REPORT;
      cnt_next     = '0;
      pending_next = mon_block;
      info_next    = mon_axis_info;
    end
  end

  // Pick the lowest pending monitor so the registered entry is ready the cycle it is needed
  always_comb begin
    sel_idx  = '0;
    sel_info = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (pending_next[i]) begin
        sel_idx  = IDX_W'(i);
        sel_info = info_next[i*INFO_W +: INFO_W];
      end
    end
    sel_last = ($countones(pending_next) == 1);
  end

  // State and registered outputs; a synchronous reset clears everything, even mid-report
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      info_regs  <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      info_q     <= '0;
      last_q     <= 1'b0;
      deadlock_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pending    <= pending_next;
      info_regs  <= info_next;
      valid_q    <= (state_next == REPORT);
      idx_q      <= (state_next == REPORT) ? sel_idx  : '0;
      info_q     <= (state_next == REPORT) ? sel_info : '0;
      last_q     <= (state_next == REPORT) ? sel_last : 1'b0;
      deadlock_q <= deadlock_q | snapshot;
      abort_q    <= (state_next == HALT);
    end
  end

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Self-checking bench for aesl_deadlock_report_ctrl (NUM_MON=2, INFO_W=1, CONFIRM_CYCLES=4).
// The bench checks outputs in three ways: a vector table, corner-case
// sequences, and a randomized run against a queue-based reference model.
module tb_aesl_deadlock_report_ctrl;
  localparam int NM = 2;
  localparam int IW = 1;
  localparam int XW = 1;
  localparam int CC = 4;

  logic          clock;
  logic          reset;
  logic          ap_start;
  logic          ap_done;
  logic [NM-1:0] mon_block;
  logic [NM*IW-1:0] mon_axis_info;
  logic          deadlock;
  logic          sim_abort;

  int checks = 0;
  int errors = 0;

  aesl_deadlock_report_ctrl_if #(.IDX_W(XW), .INFO_W(IW)) rpt_bus ();

  aesl_deadlock_report_ctrl #(
    .NUM_MON(NM), .INFO_W(IW), .IDX_W(XW), .CONFIRM_CYCLES(CC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .mon_block(mon_block),
    .mon_axis_info(mon_axis_info),
    .rpt(rpt_bus.master),
    .deadlock(deadlock),
    .sim_abort(sim_abort)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: block streak length, queue of entries still to report, sticky flags
  typedef struct { int idx; int info; } ent_t;
  ent_t q[$];
  int   streak = 0;
  bit   active = 0;
  bit   halted = 0;
  bit   dl_m   = 0;

  task automatic modelUpdate(input logic rst, st, dn, input logic [1:0] blk, inf, input logic rdy);
    if (rst) begin
      q.delete();
      streak = 0; active = 0; halted = 0; dl_m = 0;
    end else if (halted) begin
    end else if (q.size() > 0) begin
      if (rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) halted = 1;
      end
    end else if (!active) begin
      if (st) begin active = 1; streak = 0; end
    end else if (dn) begin
      active = 0; streak = 0;
    end else if (blk != 2'b00) begin
      streak++;
      if (streak >= CC) begin
        for (int i = 0; i < NM; i++)
          if (blk[i]) q.push_back('{i, int'(inf[i])});
        dl_m = 1; streak = 0;
      end
    end else begin
      streak = 0;
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit v;
    v = (q.size() > 0);
    checkValue("model_valid", 32'(rpt_bus.rpt_valid), 32'(v));
    checkValue("model_deadlock", 32'(deadlock), 32'(dl_m));
    checkValue("model_abort", 32'(sim_abort), 32'(halted));
    if (v) begin
      checkValue("model_idx", 32'(rpt_bus.rpt_idx), 32'(q[0].idx));
      checkValue("model_info", 32'(rpt_bus.rpt_info), 32'(q[0].info));
      checkValue("model_last", 32'(rpt_bus.rpt_last), 32'(q.size() == 1));
    end
  endtask

  // Drive one edge's inputs at the falling edge, step the model on the rising edge, compare at the next falling edge
  task automatic applyStimulus(input logic rst, st, dn, input logic [1:0] blk, inf, input logic rdy);
    reset = rst; ap_start = st; ap_done = dn; mon_block = blk; mon_axis_info = inf;
    rpt_bus.rpt_ready = rdy;
    @(posedge clock);
    modelUpdate(rst, st, dn, blk, inf, rdy);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic expectOutputs(input string tag, input bit v, input int idx, input int inf,
                               input bit last, input bit dl, input bit ab, input bit full);
    checkValue({tag, "_valid"}, 32'(rpt_bus.rpt_valid), 32'(v));
    checkValue({tag, "_deadlock"}, 32'(deadlock), 32'(dl));
    checkValue({tag, "_abort"}, 32'(sim_abort), 32'(ab));
    if (v || full) begin
      checkValue({tag, "_idx"}, 32'(rpt_bus.rpt_idx), 32'(idx));
      checkValue({tag, "_info"}, 32'(rpt_bus.rpt_info), 32'(inf));
      checkValue({tag, "_last"}, 32'(rpt_bus.rpt_last), 32'(last));
    end
  endtask

  typedef struct {
    logic rst, st, dn; logic [1:0] blk, inf; logic rdy;
    bit v; int idx; int info; bit last, dl, ab;
  } vec_t;
  vec_t vecs[$];

  task automatic addVec(input logic rst, st, dn, input logic [1:0] blk, inf, input logic rdy,
                        input bit v, input int idx, info, input bit last, dl, ab);
    vec_t e;
    e.rst = rst; e.st = st; e.dn = dn; e.blk = blk; e.inf = inf; e.rdy = rdy;
    e.v = v; e.idx = idx; e.info = info; e.last = last; e.dl = dl; e.ab = ab;
    vecs.push_back(e);
  endtask

  // Test sequence: table, corner cases, randomized run, then the summary line
  initial begin
    logic [1:0] blk_r;
    reset = 1'b1; ap_start = 1'b0; ap_done = 1'b0; mon_block = '0; mon_axis_info = '0;
    rpt_bus.rpt_ready = 1'b0;

    // Interrupted streak, then a full streak on monitor 0
    addVec(1,0,0,2'b00,2'b00,0, 0,0,0,0,0,0);
    addVec(0,1,0,2'b00,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b00,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 0,0,0,0,0,0);
    addVec(0,0,0,2'b01,2'b00,0, 1,0,0,1,1,0);
    addVec(0,0,0,2'b00,2'b00,1, 0,0,0,0,1,1);
    addVec(1,0,0,2'b00,2'b00,0, 0,0,0,0,0,0);
    // Both monitors blocked, info=10, back-to-back reports
    addVec(0,1,0,2'b00,2'b00,1, 0,0,0,0,0,0);
    addVec(0,0,0,2'b11,2'b10,1, 0,0,0,0,0,0);
    addVec(0,0,0,2'b11,2'b10,1, 0,0,0,0,0,0);
    addVec(0,0,0,2'b11,2'b10,1, 0,0,0,0,0,0);
    addVec(0,0,0,2'b11,2'b10,1, 1,0,0,0,1,0);
    addVec(0,0,0,2'b00,2'b00,1, 1,1,1,1,1,0);
    addVec(0,0,0,2'b00,2'b00,1, 0,0,0,0,1,1);
    addVec(1,0,0,2'b00,2'b00,0, 0,0,0,0,0,0);

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].dn, vecs[i].blk, vecs[i].inf, vecs[i].rdy);
      expectOutputs($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].info,
                    vecs[i].last, vecs[i].dl, vecs[i].ab, vecs[i].rst);
    end

    // Sink stalls for five cycles; the entry must hold while live inputs wiggle
    applyStimulus(0,1,0,2'b00,2'b00,0);
    for (int i = 0; i < CC; i++) applyStimulus(0,0,0,2'b10,2'b10,0);
    expectOutputs("stall0", 1,1,1,1,1,0,0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, logic'(i[0]), logic'(i[1]), 2'(i), 2'(~i), 0);
      expectOutputs($sformatf("stall%0d", i), 1,1,1,1,1,0,0);
    end
    applyStimulus(0,0,0,2'b00,2'b00,1);
    expectOutputs("stall_accept", 0,0,0,0,1,1,0);

    // ap_done on the would-be confirming edge wins; blocking in IDLE is ignored
    applyStimulus(1,0,0,2'b00,2'b00,0);
    applyStimulus(0,1,0,2'b00,2'b00,0);
    for (int i = 0; i < CC - 1; i++) applyStimulus(0,0,0,2'b01,2'b00,1);
    applyStimulus(0,0,1,2'b01,2'b00,1);
    expectOutputs("done_wins", 0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) applyStimulus(0,0,0,2'b01,2'b00,1);
    expectOutputs("idle_ignores", 0,0,0,0,0,0,0);

    // Reset in the middle of a report, then a clean re-report
    applyStimulus(0,1,0,2'b00,2'b00,0);
    for (int i = 0; i < CC; i++) applyStimulus(0,0,0,2'b01,2'b01,0);
    expectOutputs("pre_reset", 1,0,1,1,1,0,0);
    applyStimulus(1,0,0,2'b01,2'b01,0);
    expectOutputs("mid_reset", 0,0,0,0,0,0,1);
    applyStimulus(0,1,0,2'b00,2'b00,0);
    for (int i = 0; i < CC; i++) applyStimulus(0,0,0,2'b10,2'b10,0);
    expectOutputs("re_report", 1,1,1,1,1,0,0);

    // Mask changes on the last confirm cycle; only the final value is captured
    applyStimulus(1,0,0,2'b00,2'b00,0);
    applyStimulus(0,1,0,2'b00,2'b00,0);
    for (int i = 0; i < CC - 1; i++) applyStimulus(0,0,0,2'b01,2'b00,0);
    applyStimulus(0,0,0,2'b10,2'b10,0);
    expectOutputs("mask_change", 1,1,1,1,1,0,0);
    applyStimulus(0,0,0,2'b00,2'b00,1);
    expectOutputs("mask_accept", 0,0,0,0,1,1,0);

    // Randomized run with sticky block patterns so confirmations actually occur
    blk_r = 2'b00;
    applyStimulus(1,0,0,2'b00,2'b00,0);
    for (int n = 0; n < 4000; n++) begin
      logic rst_r;
      if ($urandom_range(0, 4) == 0) blk_r = 2'($urandom_range(0, 3));
      rst_r = (halted && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      applyStimulus(rst_r,
                    logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 24) == 0),
                    blk_r,
                    2'($urandom_range(0, 3)),
                    logic'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_report_ctrl.md
Name: aesl_deadlock_report_ctrl

Overview:
- Supervises the per-dataflow-region deadlock monitors during co-simulation.
- Arms on kernel start and confirms that a monitor `block` flag persists for a programmable number of cycles.
- On confirmation, snapshots every monitor's block flag and AXI-stream block info, then serially reports each blocked monitor to the testbench log sink over a valid/ready handshake.
- After the last report it raises a sticky simulation-abort.

Parameters:
- NUM_MON, 2, number of deadlock monitors supervised (>=1).
- INFO_W, 1, width of each monitor's axis_block_info vector (>=1).
- IDX_W, 1, width of report index; must satisfy 2**IDX_W >= NUM_MON.
- CONFIRM_CYCLES, 4, consecutive cycles of block required to declare deadlock (>=1).

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  kernel start pulse/level from bench.
- ap_done  in  1  kernel completion pulse.
- mon_block  in  NUM_MON  per-monitor block flag; bit i from monitor i.
- mon_axis_info  in  NUM_MON*INFO_W  packed info; monitor i at [i*INFO_W +: INFO_W].
- rpt_valid  out  1  report entry valid.
- rpt_ready  in  1  sink accepts entry.
- rpt_idx  out  IDX_W  monitor index of current entry.
- rpt_info  out  INFO_W  snapshotted axis info of that monitor.
- rpt_last  out  1  current entry is final one.
- deadlock  out  1  sticky deadlock declared.
- sim_abort  out  1  sticky; all reports delivered.

Behaviour:
- Reset applies on any edge with reset=1, including mid-operation:
  - state=IDLE, cnt=0, pending mask=0, info regs=0.
  - All outputs 0.
- All outputs are registered.
- any_block = |mon_block.
- FSM states: IDLE, ARMED, CONFIRM, REPORT, HALT.
- IDLE:
  - ap_start=1 -> ARMED.
  - Block inputs are ignored.
- ARMED:
  - ap_done=1 -> IDLE. ap_done has priority over any_block in ARMED and CONFIRM.
  - Else if any_block and CONFIRM_CYCLES==1 -> snapshot, REPORT.
  - Else if any_block -> CONFIRM with cnt=1.
- CONFIRM:
  - ap_done=1 -> IDLE, cnt=0.
  - any_block=0 -> ARMED, cnt=0. Persistence must be uninterrupted.
  - any_block=1 and cnt==CONFIRM_CYCLES-1 -> snapshot, REPORT.
  - Else cnt++.
  - cnt width is clog2(CONFIRM_CYCLES+1); it never wraps.
- Snapshot, taken on the confirming edge:
  - pending <= mon_block and info regs <= mon_axis_info, both as sampled on that edge.
  - deadlock <= 1.
  - The set of blocking monitors may change during CONFIRM; only the final-edge value is captured.
  - pending is nonzero at REPORT entry.
- Latency: if any_block is 1 on edges t..t+CONFIRM_CYCLES-1, deadlock and rpt_valid are 1 in the cycle after edge t+CONFIRM_CYCLES-1.
- REPORT:
  - rpt_valid=1.
  - rpt_idx = index of lowest set bit of pending.
  - rpt_info = info slice for that index.
  - rpt_last = 1 iff pending has exactly one bit set.
  - rpt_idx, rpt_info and rpt_last are held stable while rpt_valid & !rpt_ready.
  - On rpt_valid & rpt_ready: clear that bit. If rpt_last -> HALT with rpt_valid<=0; else the next entry is presented in the following cycle with no bubble.
  - Live mon_block, ap_done and ap_start are ignored in REPORT.
- HALT:
  - sim_abort=1, deadlock=1, rpt_valid=0.
  - Held until reset; all inputs ignored.
- ap_start arriving while ARMED or CONFIRM is ignored.
- Simultaneous ap_done and a confirming edge: ap_done wins, no deadlock is declared.

Test Plan (NUM_MON=2, INFO_W=1, CONFIRM_CYCLES=4):
1. ap_start, then mon_block=01 for 3 cycles, then 00 -> deadlock stays 0, state returns ARMED; a later 4-cycle run of 01 -> deadlock=1.
2. ap_start, mon_block=11 with info=10 held 4 cycles, rpt_ready=1:
   - Entry 1 (first cycle after confirm): rpt_idx=0, info=0, last=0.
   - Entry 2 (next cycle): rpt_idx=1, info=1, last=1.
   - sim_abort=1 the cycle after entry 2.
3. Confirmed block on monitor 1 with rpt_ready=0 for 5 cycles:
   - rpt_valid, idx=1, info and last=1 stable for all 5 cycles.
   - Accept on the 6th cycle -> sim_abort=1 next cycle.
4. mon_block=01 held while ap_done pulses on the 4th block cycle -> no deadlock; FSM in IDLE; subsequent block is ignored until ap_start.
5. Reset asserted during REPORT with one entry pending -> next cycle all outputs 0; a new ap_start plus 4 block cycles re-reports correctly.
6. Block mask changes 01->10 in the last CONFIRM cycle -> single report with rpt_idx=1.
